// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences one data-memory load/store per instruction over a valid/ready bus.
// Define DM_TIMEOUT_EN to add a REQ/WAIT watchdog that aborts the access with bus_err.

module dm_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        ld_en,
   input  logic        st_en,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] ld_data_q, ld_data_d;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic [3:0]  be_q;

   logic        is_byte, is_half, aligned, access, start;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_ext;

`ifdef DM_TIMEOUT_EN
   localparam int CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            err_q, err_d;
`endif

   // Decode access size, check alignment, and build byte enables and replicated store data.
   // funct3[1:0] of 10/11 (including 110/111) is treated as a word access.
   always_comb begin
      is_byte  = (funct3[1:0] == 2'b00);
      is_half  = (funct3[1:0] == 2'b01);
      aligned  = is_byte | (is_half & ~addr[0]) |
                 (~is_byte & ~is_half & (addr[1:0] == 2'b00));
      access   = ld_en | st_en;
      start    = access & aligned & (state_q == IDLE);
      misalign = access & ~aligned & (state_q == IDLE);
      be_c     = 4'b1111;
      wdata_c  = wdata;
      if (is_byte) begin
         be_c    = 4'b0001 << addr[1:0];
         wdata_c = {4{wdata[7:0]}};
      end else if (is_half) begin
         be_c    = 4'b0011 << addr[1:0];
         wdata_c = {2{wdata[15:0]}};
      end
   end

   // Select the addressed lane of the read word and sign/zero extend it per the captured funct3.
   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (addr_q[1:0])
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         2'd3:    byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_ext   = mem_rdata;
      case (funct3_q[1:0])
         2'b00:   ld_ext = funct3_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   ld_ext = funct3_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Next-state logic for the IDLE/REQ/WAIT/DONE sequencer, including the optional watchdog.
   always_comb begin
      state_d   = state_q;
      ld_data_d = ld_data_q;
`ifdef DM_TIMEOUT_EN
      cnt_inc   = cnt_q + CntW'(1);
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
`ifdef DM_TIMEOUT_EN
               cnt_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         REQ: begin
`ifdef DM_TIMEOUT_EN
            cnt_d = cnt_inc;
            if (cnt_inc == TimeoutVal) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else if (mem_req_ready) begin
               state_d = WAIT;
            end
`else
            if (mem_req_ready) state_d = WAIT;
`endif
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               if (!we_q) ld_data_d = ld_ext;
               state_d = DONE;
            end
`ifdef DM_TIMEOUT_EN
            else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TimeoutVal) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, load result and captured request registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         ld_data_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         funct3_q  <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
`ifdef DM_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ld_data_q <= ld_data_d;
`ifdef DM_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
         if (start) begin
            addr_q   <= addr;
            wdata_q  <= wdata_c;
            funct3_q <= funct3;
            we_q     <= st_en;
            be_q     <= be_c;
         end
      end
   end

   assign stall         = start | (state_q == REQ) | (state_q == WAIT);
   assign mem_req_valid = (state_q == REQ);
   assign mem_we        = we_q;
   assign mem_addr      = {addr_q[31:2], 2'b00};
   assign mem_be        = be_q;
   assign mem_wdata     = wdata_q;
   assign ld_data       = ld_data_q;
`ifdef DM_TIMEOUT_EN
   assign ld_valid      = (state_q == DONE) & ~we_q & ~err_q;
   assign bus_err       = (state_q == DONE) & err_q;
`else
   assign ld_valid      = (state_q == DONE) & ~we_q;
   assign bus_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl; the bench plays the memory side of the bus.
// Build with DM_TIMEOUT_EN to also exercise the watchdog abort.

module tb_dm_access_ctrl;

   logic        clk, arst_n, ld_en, st_en;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, ld_valid, misalign, bus_err;
   logic [31:0] ld_data;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int failures = 0;

   localparam int TO = 8;

   int          obsStall, obsMis, obsLdv, obsLdvCyc, obsErr, obsErrCyc, obsReq;
   logic        obsHang, obsUnstable, obsWe;
   logic [31:0] obsAddr, obsWdata, obsLdData;
   logic [3:0]  obsBe;
   logic [31:0] expLast;

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   dm_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .arst_n(arst_n), .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
      .misalign(misalign), .bus_err(bus_err), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   // Holds the instruction until the pipeline is released, answering the bus like a memory
   // that accepts after rdyDelay request cycles and responds one cycle after acceptance.
   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int rdyDelay);
      int   reqSeen;
      logic rspNext, done;
      obsStall = 0; obsMis = 0; obsLdv = 0; obsLdvCyc = -1; obsErr = 0; obsErrCyc = -1;
      obsReq = 0; obsUnstable = 1'b0; obsWe = 1'b0; obsAddr = '0; obsWdata = '0; obsBe = '0;
      reqSeen = 0; rspNext = 1'b0; done = 1'b0;
      @(negedge clk);
      ld_en = ld; st_en = st; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      #1;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (stall) obsStall++;
         if (misalign) obsMis++;
         if (ld_valid) begin obsLdv++; obsLdvCyc = cyc; end
         if (bus_err) begin obsErr++; obsErrCyc = cyc; end
         if (mem_req_valid) begin
            if (obsReq == 0) begin
               obsAddr = mem_addr; obsBe = mem_be; obsWdata = mem_wdata; obsWe = mem_we;
            end else if (mem_addr !== obsAddr || mem_be !== obsBe ||
                         mem_wdata !== obsWdata || mem_we !== obsWe) begin
               obsUnstable = 1'b1;
            end
            obsReq++;
         end
         mem_rsp_valid = rspNext;
         rspNext       = 1'b0;
         mem_req_ready = mem_req_valid && (reqSeen >= rdyDelay);
         if (mem_req_valid) begin
            if (mem_req_ready) rspNext = 1'b1;
            reqSeen++;
         end
         if (cyc > 0) begin addr = ~a; wdata = ~wd; end
         if (!stall) begin
            done = 1'b1;
            ld_en = 1'b0; st_en = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
         end
         @(negedge clk); #1;
      end
      obsHang = !done;
      ld_en = 1'b0; st_en = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      if (stall) obsStall++;
      if (misalign) obsMis++;
      if (ld_valid) obsLdv++;
      if (bus_err) obsErr++;
      if (mem_req_valid) obsReq++;
      obsLdData = ld_data;
   endtask

   task automatic test_reset;
      arst_n = 1'b0; ld_en = 1'b0; st_en = 1'b0; funct3 = '0; addr = '0; wdata = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({stall, ld_valid, misalign, bus_err, mem_req_valid, mem_we} !== 6'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b expected 000000",
                  {stall, ld_valid, misalign, bus_err, mem_req_valid, mem_we});
      end
      checks++;
      if (ld_data !== 32'h0) begin
         failures++; $display("[TB] FAIL reset_ld_data: got %h expected 00000000", ld_data);
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
         failures++;
         $display("[TB] FAIL reset_bus: got %h/%h/%b expected zeros", mem_addr, mem_wdata, mem_be);
      end
      @(negedge clk);
      arst_n = 1'b1;
      expLast = 32'h0;
   endtask

   task automatic test_load_word;
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
      checks++;
      if (obsHang !== 1'b0) begin failures++; $display("[TB] FAIL lw_hang: got 1 expected 0"); end
      checks++;
      if (obsBe !== 4'b1111 || obsAddr !== 32'h100 || obsWe !== 1'b0) begin
         failures++;
         $display("[TB] FAIL lw_req: got be=%b addr=%h we=%b expected be=1111 addr=00000100 we=0",
                  obsBe, obsAddr, obsWe);
      end
      checks++;
      if (obsStall !== 3) begin
         failures++; $display("[TB] FAIL lw_stall_cycles: got %0d expected 3", obsStall);
      end
      checks++;
      if (obsLdv !== 1 || obsLdvCyc !== 3) begin
         failures++;
         $display("[TB] FAIL lw_ld_valid: got count=%0d cycle=%0d expected count=1 cycle=3",
                  obsLdv, obsLdvCyc);
      end
      checks++;
      if (obsLdData !== 32'hDEAD_BEEF) begin
         failures++; $display("[TB] FAIL lw_data: got %h expected deadbeef", obsLdData);
      end
      checks++;
      if (obsErr !== 0 || obsMis !== 0) begin
         failures++;
         $display("[TB] FAIL lw_side_pulses: got err=%0d mis=%0d expected 0/0", obsErr, obsMis);
      end
      expLast = 32'hDEAD_BEEF;
   endtask

   task automatic test_load_extend;
      logic [2:0]  f3s [6];
      logic [31:0] as [6];
      logic [31:0] rds [6];
      logic [3:0]  bes [6];
      logic [31:0] exps [6];
      f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b110};
      as   = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h108};
      rds  = '{32'h8012_3456, 32'h8012_3456, 32'h8001_1234, 32'h1234_F00D,
               32'h0000_7F00, 32'h8765_4321};
      bes  = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
      exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00D,
               32'h0000_007F, 32'h8765_4321};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, f3s[i], as[i], 32'h0, rds[i], 0);
         checks++;
         if (obsBe !== bes[i] || obsHang !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ld_ext_be[%0d]: got be=%b hang=%b expected be=%b hang=0",
                     i, obsBe, obsHang, bes[i]);
         end
         checks++;
         if (obsLdData !== exps[i] || obsLdv !== 1) begin
            failures++;
            $display("[TB] FAIL ld_ext_data[%0d]: got %h (ld_valid count %0d) expected %h (1)",
                     i, obsLdData, obsLdv, exps[i]);
         end
         expLast = exps[i];
      end
   endtask

   task automatic test_store;
      logic        lds [4];
      logic [2:0]  f3s [4];
      logic [31:0] as [4];
      logic [31:0] wds [4];
      logic [3:0]  bes [4];
      logic [31:0] ews [4];
      logic [31:0] eas [4];
      lds = '{1'b0, 1'b0, 1'b0, 1'b1};
      f3s = '{3'b000, 3'b001, 3'b010, 3'b010};
      as  = '{32'h201, 32'h202, 32'h204, 32'h208};
      wds = '{32'h1234_5678, 32'hAAAA_BEEF, 32'hCAFE_F00D, 32'h0102_0304};
      bes = '{4'b0010, 4'b1100, 4'b1111, 4'b1111};
      ews = '{32'h7878_7878, 32'hBEEF_BEEF, 32'hCAFE_F00D, 32'h0102_0304};
      eas = '{32'h200, 32'h200, 32'h204, 32'h208};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(lds[i], 1'b1, f3s[i], as[i], wds[i], 32'hFFFF_FFFF, 0);
         checks++;
         if (obsWe !== 1'b1 || obsBe !== bes[i] || obsAddr !== eas[i] || obsHang !== 1'b0) begin
            failures++;
            $display("[TB] FAIL st_req[%0d]: got we=%b be=%b addr=%h expected we=1 be=%b addr=%h",
                     i, obsWe, obsBe, obsAddr, bes[i], eas[i]);
         end
         checks++;
         if (obsWdata !== ews[i]) begin
            failures++;
            $display("[TB] FAIL st_wdata[%0d]: got %h expected %h", i, obsWdata, ews[i]);
         end
         checks++;
         if (obsLdv !== 0 || obsLdData !== expLast || obsStall !== 3) begin
            failures++;
            $display("[TB] FAIL st_no_load[%0d]: got ldv=%0d ld_data=%h stall=%0d expected 0 %h 3",
                     i, obsLdv, obsLdData, obsStall, expLast);
         end
      end
   endtask

   task automatic test_misalign;
      logic        sts [4];
      logic [2:0]  f3s [4];
      logic [31:0] as [4];
      sts = '{1'b0, 1'b0, 1'b0, 1'b1};
      f3s = '{3'b010, 3'b001, 3'b101, 3'b010};
      as  = '{32'h102, 32'h101, 32'h103, 32'h206};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(~sts[i], sts[i], f3s[i], as[i], 32'h5555_5555, 32'h0, 0);
         checks++;
         if (obsMis !== 1 || obsReq !== 0 || obsStall !== 0 || obsLdv !== 0 || obsHang !== 1'b0) begin
            failures++;
            $display("[TB] FAIL misalign[%0d]: got mis=%0d req=%0d stall=%0d ldv=%0d expected 1 0 0 0",
                     i, obsMis, obsReq, obsStall, obsLdv);
         end
         checks++;
         if (obsLdData !== expLast) begin
            failures++;
            $display("[TB] FAIL misalign_ld_data[%0d]: got %h expected %h", i, obsLdData, expLast);
         end
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      ld_en = 1'b1; st_en = 1'b0; funct3 = 3'b010; addr = 32'h400; wdata = 32'h0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      @(negedge clk);
      ld_en = 1'b0;
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h400) begin
         failures++;
         $display("[TB] FAIL rstmid_pre: got valid=%b addr=%h expected 1 00000400",
                  mem_req_valid, mem_addr);
      end
      #2 arst_n = 1'b0;
      #1;
      checks++;
      if ({stall, mem_req_valid, ld_valid, bus_err, mem_we} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL rstmid_flags: got %b expected 00000",
                  {stall, mem_req_valid, ld_valid, bus_err, mem_we});
      end
      checks++;
      if (ld_data !== 32'h0 || mem_addr !== 32'h0 || mem_be !== 4'b0) begin
         failures++;
         $display("[TB] FAIL rstmid_regs: got ld_data=%h addr=%h be=%b expected zeros",
                  ld_data, mem_addr, mem_be);
      end
      @(negedge clk);
      arst_n = 1'b1;
      expLast = 32'h0;
   endtask

   task automatic test_ready_stall;
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0BAD_F00D, 5);
      checks++;
      if (obsStall !== 8 || obsReq !== 6 || obsHang !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ready_ld_timing: got stall=%0d req=%0d expected 8 6", obsStall, obsReq);
      end
      checks++;
      if (obsUnstable !== 1'b0 || obsAddr !== 32'h300 || obsBe !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL ready_ld_stable: got unstable=%b addr=%h be=%b expected 0 00000300 1111",
                  obsUnstable, obsAddr, obsBe);
      end
      checks++;
      if (obsLdv !== 1 || obsLdvCyc !== 8 || obsLdData !== 32'h0BAD_F00D) begin
         failures++;
         $display("[TB] FAIL ready_ld_result: got ldv=%0d at %0d data=%h expected 1 at 8 0badf00d",
                  obsLdv, obsLdvCyc, obsLdData);
      end
      expLast = 32'h0BAD_F00D;
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h304, 32'h55AA_33CC, 32'h0, 5);
      checks++;
      if (obsUnstable !== 1'b0 || obsWdata !== 32'h55AA_33CC || obsStall !== 8 || obsLdv !== 0) begin
         failures++;
         $display("[TB] FAIL ready_st: got unstable=%b wdata=%h stall=%0d ldv=%0d expected 0 55aa33cc 8 0",
                  obsUnstable, obsWdata, obsStall, obsLdv);
      end
   endtask

`ifdef DM_TIMEOUT_EN
   task automatic test_timeout;
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h1111_1111, 1000);
      checks++;
      if (obsErr !== 1 || obsErrCyc !== TO + 1 || obsHang !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_bus_err: got count=%0d cycle=%0d expected 1 at %0d",
                  obsErr, obsErrCyc, TO + 1);
      end
      checks++;
      if (obsLdv !== 0 || obsLdData !== expLast || obsStall !== TO + 1) begin
         failures++;
         $display("[TB] FAIL timeout_no_load: got ldv=%0d data=%h stall=%0d expected 0 %h %0d",
                  obsLdv, obsLdData, obsStall, expLast, TO + 1);
      end
   endtask
`endif

   // Test sequence: reset, loads, stores, misalignment, mid-transaction reset, backpressure, timeout.
   initial begin
      test_reset();
      test_load_word();
      test_load_extend();
      test_store();
      test_misalign();
      test_reset_mid();
      test_ready_stall();
`ifdef DM_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
